// File: rtl/ram_sp_dp_param.sv
// ram_sp_dp_param: parametrised RAM, port A read/write, port B read-only, hardware clear engine, optional output register
module ram_sp_dp_param #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int OUT_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  output logic              busy,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] a_dout,
  output logic              a_valid,
  input  logic              b_en,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_dout,
  output logic              b_valid
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic {S_CLEAR, S_RUN} state_t;
  state_t            r_state;
  logic [ADDR_W:0]   r_clr_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_a_d1, r_b_d1;
  logic              r_a_v1, r_b_v1;
  logic              w_run, w_we, w_hit;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  assign w_run   = r_state == S_RUN;
  assign busy    = !w_run;
  assign w_we    = w_run ? (a_en & a_we) : 1'b1;
  assign w_waddr = w_run ? a_addr : r_clr_cnt[ADDR_W-1:0];
  assign w_wdata = w_run ? a_din : '0;
  assign w_hit   = a_en & a_we & (a_addr == b_addr);
  // clear engine: sweep every address once, then hand the array to the ports
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end else if (!w_run) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
      if (r_clr_cnt[ADDR_W-1:0] == {ADDR_W{1'b1}}) r_state <= S_RUN;
    end else if (clr) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end
  end
  // single write port shared by the clear sweep and port A
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end
  // first read stage: write-first on A, A-to-B bypass on same-address collision
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_v1 <= 1'b0;
      r_b_v1 <= 1'b0;
      r_a_d1 <= '0;
      r_b_d1 <= '0;
    end else begin
      r_a_v1 <= w_run & a_en;
      r_b_v1 <= w_run & b_en;
      if (w_run && a_en) r_a_d1 <= a_we ? a_din : r_mem[a_addr];
      if (w_run && b_en) r_b_d1 <= w_hit ? a_din : r_mem[b_addr];
    end
  end
  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_W-1:0] r_a_d2, r_b_d2;
    logic              r_a_v2, r_b_v2;
    // second stage drains regardless of busy so in-flight reads still complete
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_a_v2 <= 1'b0;
        r_b_v2 <= 1'b0;
        r_a_d2 <= '0;
        r_b_d2 <= '0;
      end else begin
        r_a_v2 <= r_a_v1;
        r_b_v2 <= r_b_v1;
        if (r_a_v1) r_a_d2 <= r_a_d1;
        if (r_b_v1) r_b_d2 <= r_b_d1;
      end
    end
    assign a_dout  = r_a_d2;
    assign a_valid = r_a_v2;
    assign b_dout  = r_b_d2;
    assign b_valid = r_b_v2;
  end else begin : g_nreg
    assign a_dout  = r_a_d1;
    assign a_valid = r_a_v1;
    assign b_dout  = r_b_d1;
    assign b_valid = r_b_v1;
  end
endmodule
